// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory request unit.
package mem_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } state_e;
endpackage

// File: rtl/mem_request_unit_if.sv
// Requester/RAM bus of the memory request unit; slave = the unit, master = its environment.
interface mem_request_unit_if
  #(parameter int ADDR_W = mem_pkg::MEM_ADDR_W,
    parameter int DATA_W = mem_pkg::MEM_DATA_W);
  logic              imem_ren;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_load;
  logic              i_ready;
  logic              dmem_ren;
  logic              dmem_wen;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_store;
  logic [DATA_W-1:0] dmem_load;
  logic              d_ready;
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_busy;

  modport slave (
    input  imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store,
           ram_load, ram_busy,
    output imem_load, i_ready, dmem_load, d_ready,
           ram_ren, ram_wen, ram_addr, ram_store
  );

  modport master (
    output imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store,
           ram_load, ram_busy,
    input  imem_load, i_ready, dmem_load, d_ready,
           ram_ren, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/instr_buffer.sv
// One-entry instruction buffer (valid, address, data); only exists when INSTR_BUFFER_EN is defined.
`ifdef INSTR_BUFFER_EN
module instr_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              inv_i,
  input  logic [ADDR_W-1:0] inv_addr_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr_i;
      data_q  <= fill_data_i;
    end else if (inv_i && inv_addr_i == addr_q) begin
      valid_q <= 1'b0;
    end
  end

  assign hit_o  = valid_q && (lookup_addr_i == addr_q);
  assign data_o = data_q;
endmodule
`endif

// File: rtl/mem_request_unit.sv
// Arbitrates instruction fetches and data accesses onto one RAM port (data first).
// Define INSTR_BUFFER_EN to add a one-entry instruction buffer that short-cuts repeated fetches.
module mem_request_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              nRST,
  mem_request_unit_if.slave bus
);
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic              ren_q, wen_q;
  logic [DATA_W-1:0] iload_q, dload_q;
  logic              irdy_q, drdy_q;

  logic              dreq;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  assign dreq = bus.dmem_ren | bus.dmem_wen;

`ifdef INSTR_BUFFER_EN
  instr_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ibuf (
    .clk          (clk),
    .nRST         (nRST),
    .fill_i       (state_q == IACC && !bus.ram_busy),
    .fill_addr_i  (addr_q),
    .fill_data_i  (bus.ram_load),
    .inv_i        (state_q == DACC && !bus.ram_busy && wen_q),
    .inv_addr_i   (addr_q),
    .lookup_addr_i(bus.imem_addr),
    .hit_o        (hit),
    .data_o       (hit_data)
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // Strobes are registers cleared by the async reset, so an aborted access drops them at once.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      irdy_q  <= 1'b0;
      drdy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dreq) begin
            addr_q  <= bus.dmem_addr;
            store_q <= bus.dmem_store;
            wen_q   <= bus.dmem_wen;
            ren_q   <= ~bus.dmem_wen;   // write wins when both are requested
            state_q <= DACC;
          end else if (bus.imem_ren && hit) begin
            addr_q  <= bus.imem_addr;
            iload_q <= hit_data;
            irdy_q  <= 1'b1;
            state_q <= RESP;
          end else if (bus.imem_ren) begin
            addr_q  <= bus.imem_addr;
            store_q <= '0;
            ren_q   <= 1'b1;
            state_q <= IACC;
          end
        end
        IACC: begin
          if (!bus.ram_busy) begin
            iload_q <= bus.ram_load;
            ren_q   <= 1'b0;
            irdy_q  <= 1'b1;
            state_q <= RESP;
          end
        end
        DACC: begin
          if (!bus.ram_busy) begin
            if (ren_q) dload_q <= bus.ram_load;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            drdy_q  <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          irdy_q  <= 1'b0;
          drdy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_ren   = ren_q;
  assign bus.ram_wen   = wen_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_store = store_q;
  assign bus.imem_load = iload_q;
  assign bus.dmem_load = dload_q;
  assign bus.i_ready   = irdy_q;
  assign bus.d_ready   = drdy_q;
endmodule
